weight_stream_mem: RTL and testbench

//  - Parametrised multi-neuron weight store for one ELM layer: NUM_CH banks (one per neuron), each DEPTH x DATA_W.
//  - Host side loads weights through a simple write port. Compute side pulls one word per bank per beat on a valid/ready stream.
//  - Hides the 1-cycle BRAM read latency behind backpressure. Sits between the AXI config path and the neuron MAC array.

---
 rtl/weight_stream_mem_pkg.sv | 31 +++
 rtl/weight_stream_mem_if.sv | 47 ++++
 rtl/weight_stream_mem_bank.sv | 49 ++++
 rtl/weight_stream_mem.sv | 241 ++++++++++++++++++++++++
 tb/tb_weight_stream_mem.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/weight_stream_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : weight_mem_pkg
//  Description : Shared definitions for the ELM weight-stream store: FSM state
//                encoding, default geometry shared with the neuron modules,
//                and the even-parity helper used when WEIGHT_PARITY_EN is set.
//  Revision    : 1.0  initial release
// ============================================================================
package weight_mem_pkg;

    // Default geometry shared with the neuron MAC modules.
    localparam int DATA_W_DEFAULT = 16;
    localparam int DEPTH_DEFAULT  = 784;

    // Widest word the parity helper accepts; narrower words are zero-extended,
    // which does not change their parity.
    localparam int PAR_MAX_W = 64;

    // Stream controller state encoding.
    typedef logic [1:0] state_t;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Even parity bit: XOR of all data bits, so data plus parity XORs to 0.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/weight_stream_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : weight_stream_mem_if
//  Description : Bundle of the host write port, stream control and the
//                valid/ready weight stream of weight_stream_mem.
//                slave  : the weight store (receives writes, drives stream)
//                master : host/consumer side
//  Signals     : wr_en/wr_ch/wr_addr/wr_data  host write port
//                rd_start/busy                stream control
//                w_data/w_valid/w_ready/w_last weight stream
//                par_err                      sticky parity error
//  Revision    : 1.0  initial release
// ============================================================================
interface weight_stream_mem_if
    import weight_mem_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                     wr_en;
    logic [CH_W-1:0]          wr_ch;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     rd_start;
    logic                     busy;
    logic [NUM_CH*DATA_W-1:0] w_data;
    logic                     w_valid;
    logic                     w_ready;
    logic                     w_last;
    logic                     par_err;

    modport master (
        output wr_en, wr_ch, wr_addr, wr_data, rd_start, w_ready,
        input  busy, w_data, w_valid, w_last, par_err
    );

    modport slave (
        input  wr_en, wr_ch, wr_addr, wr_data, rd_start, w_ready,
        output busy, w_data, w_valid, w_last, par_err
    );

endinterface
`default_nettype wire

// File: rtl/weight_stream_mem_bank.sv
`default_nettype none
// ============================================================================
//  Module      : weight_bram_bank
//  Description : Simple dual-port block RAM, one write port and one read port
//                with a registered output (1-cycle read latency). Contents are
//                not reset. A read and a write to the same address in one
//                cycle return the old word (read-first).
//  Ports       : clk        clock
//                wr_en_i    write strobe
//                wr_addr_i  write address (must be < DEPTH)
//                wr_data_i  write word
//                rd_en_i    read enable, data valid on rd_data_o next cycle
//                rd_addr_i  read address
//                rd_data_o  registered read word
//  Revision    : 1.0  initial release
// ============================================================================
module weight_bram_bank
    import weight_mem_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // No reset: block RAM and its output register carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/weight_stream_mem.sv
`default_nettype none
// ============================================================================
//  Module      : weight_stream_mem
//  Description : NUM_CH-bank weight store for one ELM layer. The host loads
//                words through the write port; rd_start streams addresses
//                0..DEPTH-1 of all banks in parallel as one beat per address
//                on a valid/ready stream. A 2-entry output FIFO plus a credit
//                check hides the 1-cycle RAM latency under backpressure.
//  Ports       : clk      clock, rising edge
//                rst      asynchronous active-high reset
//                wsm      weight_stream_mem_if.slave (write port, rd_start,
//                         busy, w_data/w_valid/w_ready/w_last, par_err)
//  Config      : WEIGHT_PARITY_EN - defined: each bank word carries an even
//                parity bit, checked on every handshaken beat; par_err is
//                sticky until rst. Undefined: no parity, par_err tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module weight_stream_mem
    import weight_mem_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    weight_stream_mem_if.slave  wsm
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef WEIGHT_PARITY_EN
    localparam int BANK_W = DATA_W + 1;
`else
    localparam int BANK_W = DATA_W;
`endif
    localparam int BEAT_W = NUM_CH * BANK_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                inflight_q, inflight_last_q;
    logic [1:0]          count_q, count_d;
    logic [BEAT_W-1:0]   head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic                head_last_q, head_last_d, tail_last_q, tail_last_d;

    logic                wr_ok;
    logic [BANK_W-1:0]   wr_word;
    logic                issue;
    logic [ADDR_W-1:0]   rd_addr;
    logic [BEAT_W-1:0]   rd_beat;
    logic                pop;
    logic [1:0]          occ;
    logic                credit_ok;
    logic [NUM_CH*DATA_W-1:0] w_data_out;

    // Out-of-range addresses are silently dropped.
    assign wr_ok = wsm.wr_en && ({1'b0, wsm.wr_addr} < DEPTH_LIM);

`ifdef WEIGHT_PARITY_EN
    assign wr_word = {even_parity(PAR_MAX_W'(wsm.wr_data)), wsm.wr_data};
`else
    assign wr_word = wsm.wr_data;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_bank
        localparam logic [CH_W-1:0] BANK_ID = CH_W'(k);
        logic bank_we;
        assign bank_we = wr_ok && (wsm.wr_ch == BANK_ID);

        weight_bram_bank #(
            .WIDTH (BANK_W),
            .DEPTH (DEPTH)
        ) u_bank (
            .clk       (clk),
            .wr_en_i   (bank_we),
            .wr_addr_i (wsm.wr_addr),
            .wr_data_i (wr_word),
            .rd_en_i   (issue),
            .rd_addr_i (rd_addr),
            .rd_data_o (rd_beat[k*BANK_W +: BANK_W])
        );
    end

    // ------------------------------------------------------------------
    // Read issue / FSM. A read may issue only while the words already
    // committed (buffered + in flight) leave a FIFO slot free, counting a
    // pop this cycle as freeing one. The first read issues in the same
    // cycle rd_start is accepted, so the buffer is always empty in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        pop       = (count_q != 2'd0) && wsm.w_ready;
        occ       = count_q + {1'b0, inflight_q};
        credit_ok = (occ < 2'd2) || ((occ == 2'd2) && pop);
        issue     = 1'b0;
        rd_addr   = ptr_q;
        state_d   = state_q;
        ptr_d     = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (wsm.rd_start) begin
                    issue   = 1'b1;
                    rd_addr = '0;
                    if (LAST_ADDR == '0) begin
                        ptr_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        ptr_d   = ADDR_W'(1);
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (ptr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DRAIN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // The final beat leaving the FIFO ends the stream.
        if ((state_q != S_IDLE) && pop && head_last_q) begin
            state_d = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // 2-entry output FIFO; the RAM word captured last cycle is pushed.
    // ------------------------------------------------------------------
    always_comb begin
        count_d     = count_q;
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;
        case ({inflight_q, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_data_d = rd_beat;
                    head_last_d = inflight_last_q;
                end else begin
                    tail_data_d = rd_beat;
                    tail_last_d = inflight_last_q;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_data_d = tail_data_q;
                head_last_d = tail_last_q;
                count_d     = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_data_d = rd_beat;
                    head_last_d = inflight_last_q;
                end else begin
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                    tail_data_d = rd_beat;
                    tail_last_d = inflight_last_q;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= 2'd0;
            head_data_q     <= '0;
            head_last_q     <= 1'b0;
            tail_data_q     <= '0;
            tail_last_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (rd_addr == LAST_ADDR);
            count_q         <= count_d;
            head_data_q     <= head_data_d;
            head_last_q     <= head_last_d;
            tail_data_q     <= tail_data_d;
            tail_last_q     <= tail_last_d;
        end
    end

    // Strip the parity bits (if any) from the head register.
    always_comb begin
        w_data_out = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_data_out[k*DATA_W +: DATA_W] = head_data_q[k*BANK_W +: DATA_W];
        end
    end

    assign wsm.w_data  = w_data_out;
    assign wsm.w_valid = (count_q != 2'd0);
    assign wsm.w_last  = (count_q != 2'd0) && head_last_q;
    assign wsm.busy    = (state_q != S_IDLE);

`ifdef WEIGHT_PARITY_EN
    logic par_bad;
    logic par_err_q;

    always_comb begin
        par_bad = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            par_bad = par_bad | (^head_data_q[k*BANK_W +: BANK_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else if (pop && par_bad) begin
            par_err_q <= 1'b1;
        end
    end

    assign wsm.par_err = par_err_q;
`else
    assign wsm.par_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_stream_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_weight_stream_mem
//  Description : Self-checking bench for weight_stream_mem (4 x 8 x 16).
//                A reference memory array models the bank contents; each
//                stream is expected to deliver a snapshot of that array,
//                addresses 0..7 in order. Covers latency, throughput,
//                stalls, ignored rd_start, read-first writes, async reset
//                and par_err (parity path when WEIGHT_PARITY_EN is defined).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_weight_stream_mem;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 16;
    localparam int BEAT_W = NUM_CH * DATA_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    weight_stream_mem_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    weight_stream_mem #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .wsm (bus)
    );

    logic [DATA_W-1:0] ref_mem [NUM_CH][DEPTH];
    int n_checks = 0;
    int n_fail   = 0;
    bit exp_par  = 1'b0;
    bit corrupt_armed = 1'b0;
    int corrupt_addr  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BEAT_W-1:0] model_beat(input int a);
        logic [BEAT_W-1:0] b;
        for (int k = 0; k < NUM_CH; k++) b[k*DATA_W +: DATA_W] = ref_mem[k][a];
        return b;
    endfunction

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return ((cyc - 1) % 3) == 0;   // 1,0,0,1,0,0,...
            default: return logic'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int ch, input int a, input logic [DATA_W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_ch   = 2'(ch);
        bus.wr_addr = 3'(a);
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
        ref_mem[ch][a] = d;
    endtask

    // One complete stream. Cycle 0 is the rd_start cycle. Optionally pulses
    // rd_start again while beat 3 is shown, and/or writes one word at cycle
    // wr_cyc (at or after the read of that address, so the beat keeps the
    // old value and only later streams see the new one).
    task automatic run_stream(input int mode, input bit restart_mid, input int wr_cyc,
                              input int wr_c, input int wr_a, input logic [DATA_W-1:0] wr_v);
        logic [BEAT_W-1:0] exp_beats [DEPTH];
        logic [BEAT_W-1:0] prev_data;
        logic              prev_last;
        bit                prev_stall = 1'b0;
        bit                restarted  = 1'b0;
        int idx = 0, cyc = 1, first_valid = -1, last_hs = -1;
        logic rdy;
        for (int a = 0; a < DEPTH; a++) exp_beats[a] = model_beat(a);

        bus.rd_start = 1'b1;
        bus.w_ready  = 1'b1;
        step();
        bus.rd_start = 1'b0;

        while (idx < DEPTH && cyc < 200) begin
            if (cyc == 1) check_eq("lat_pre", 64'(bus.w_valid), 64'd0);
            if (bus.w_valid && first_valid < 0) begin
                first_valid = cyc;
                check_eq("lat_first", 64'(cyc), 64'd2);
            end
            if (prev_stall) begin
                check_eq("hold_data", 64'(bus.w_data), 64'(prev_data));
                check_eq("hold_last", 64'(bus.w_last), 64'(prev_last));
            end
            check_eq("par_err", 64'(bus.par_err), 64'(exp_par));

            rdy = ready_for(mode, cyc);
            bus.w_ready = rdy;
            if (restart_mid && !restarted && idx == 3 && bus.w_valid) begin
                bus.rd_start = 1'b1;
                restarted = 1'b1;
            end
            if (cyc == wr_cyc) begin
                bus.wr_en   = 1'b1;
                bus.wr_ch   = 2'(wr_c);
                bus.wr_addr = 3'(wr_a);
                bus.wr_data = wr_v;
            end
            if (bus.w_valid && rdy) begin
                check_eq($sformatf("beat%0d_data", idx), 64'(bus.w_data), 64'(exp_beats[idx]));
                check_eq($sformatf("beat%0d_last", idx), 64'(bus.w_last), 64'(idx == DEPTH - 1));
                if (corrupt_armed && idx == corrupt_addr) exp_par = 1'b1;
                last_hs = cyc;
                idx++;
            end
            prev_stall = bus.w_valid && !rdy;
            prev_data  = bus.w_data;
            prev_last  = bus.w_last;
            step();
            bus.rd_start = 1'b0;
            bus.wr_en    = 1'b0;
            cyc++;
        end
        check_eq("stream_beats", 64'(idx), 64'(DEPTH));
        check_eq("busy_fall", 64'(bus.busy), 64'd0);
        check_eq("valid_fall", 64'(bus.w_valid), 64'd0);
        if (mode == 0) check_eq("throughput", 64'(last_hs - first_valid + 1), 64'(DEPTH));
        if (wr_cyc >= 0) ref_mem[wr_c][wr_a] = wr_v;
        bus.w_ready = 1'b1;
    endtask

    // Async reset while beat 4 is stalled at the head.
    task automatic reset_mid_stream();
        int hs = 0, guard = 0;
        bus.w_ready  = 1'b1;
        bus.rd_start = 1'b1;
        step();
        bus.rd_start = 1'b0;
        while (hs < 4 && guard < 50) begin
            if (bus.w_valid) hs++;
            step();
            guard++;
        end
        check_eq("rst_setup_hs", 64'(hs), 64'd4);
        bus.w_ready = 1'b0;
        check_eq("rst_pre_valid", 64'(bus.w_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_valid", 64'(bus.w_valid), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_last", 64'(bus.w_last), 64'd0);
        exp_par = 1'b0;
        step();
        rst = 1'b0;
        bus.w_ready = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_ch    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_start = 1'b0;
        bus.w_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy", 64'(bus.busy), 64'd0);
        check_eq("reset_valid", 64'(bus.w_valid), 64'd0);
        check_eq("reset_last", 64'(bus.w_last), 64'd0);
        check_eq("reset_par_err", 64'(bus.par_err), 64'd0);
        rst = 1'b0;
        step();

        for (int k = 0; k < NUM_CH; k++)
            for (int a = 0; a < DEPTH; a++)
                write_word(k, a, DATA_W'((k << 8) | a));

        run_stream(0, 1'b0, -1, 0, 0, '0);            // full-rate stream
        run_stream(1, 1'b0, -1, 0, 0, '0);            // 1,0,0 ready pattern
        run_stream(0, 1'b1, -1, 0, 0, '0);            // rd_start while busy ignored
        run_stream(0, 1'b0, -1, 0, 0, '0);            // fresh stream from addr 0
        run_stream(0, 1'b0, 5, 2, 5, 16'hBEEF);       // write during read of addr 5
        check_eq("bank2_a5_model", 64'(ref_mem[2][5]), 64'h0000_BEEF);
        run_stream(0, 1'b0, -1, 0, 0, '0);            // new value now visible

        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 12; w++)
                write_word($urandom_range(0, NUM_CH - 1), $urandom_range(0, DEPTH - 1),
                           DATA_W'($urandom));
            run_stream(2, 1'b0, -1, 0, 0, '0);
        end

        reset_mid_stream();
        run_stream(0, 1'b0, -1, 0, 0, '0);            // contents survive reset

`ifdef WEIGHT_PARITY_EN
        dut.g_bank[1].u_bank.mem_q[2][DATA_W] = ~dut.g_bank[1].u_bank.mem_q[2][DATA_W];
        corrupt_armed = 1'b1;
        corrupt_addr  = 2;
        run_stream(0, 1'b0, -1, 0, 0, '0);
        check_eq("par_err_set", 64'(bus.par_err), 64'd1);
        run_stream(1, 1'b0, -1, 0, 0, '0);
        check_eq("par_err_sticky", 64'(bus.par_err), 64'd1);
        rst = 1'b1;
        #1;
        exp_par = 1'b0;
        check_eq("par_err_cleared", 64'(bus.par_err), 64'd0);
        step();
        rst = 1'b0;
        step();
`else
        check_eq("par_err_off", 64'(bus.par_err), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
